// File: rtl/bitonic_sort8_asc.sv
// Sequential 8-element bitonic sorter, ascending output order.
// One bitonic stage (four compare-exchange pairs) is applied per clock over six SORT cycles.
module bitonic_sort8_asc #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             in_ready,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    output logic             done
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        SORT = 2'd2,
        OUT  = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] r_q [8];
    logic [WIDTH-1:0] r_d [8];
    logic [WIDTH-1:0] net_s [8];
    logic [2:0]       cnt_q, cnt_d;
    logic [2:0]       stage_q, stage_d;
    logic [2:0]       k_q, k_d;
    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] out_data_q, out_data_d;
    logic             done_q, done_d;

    logic [3:0]       size_s;
    logic [2:0]       dist_s;
    logic [2:0]       idx_s;
    logic [2:0]       partner_s;
    logic [2:0]       lo_s;
    logic [2:0]       hi_s;
    logic             asc_s;
    logic             swap_s;
    logic             capture_s;

    // Unsigned compare-exchange decision; equal values never swap.
    function automatic logic cx_swap(input logic [WIDTH-1:0] lo_val,
                                     input logic [WIDTH-1:0] hi_val,
                                     input logic             asc);
        logic result;
        if (asc) begin
            result = (lo_val > hi_val);
        end else begin
            result = (lo_val < hi_val);
        end
        return result;
    endfunction

    assign in_ready  = (state_q == IDLE) || (state_q == LOAD);
    assign capture_s = in_valid && in_ready;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign done      = done_q;

    // Stage (size, dist) lookup and the one-stage compare-exchange network.
    always_comb begin
        size_s    = 4'd8;
        dist_s    = 3'd1;
        idx_s     = 3'd0;
        partner_s = 3'd0;
        lo_s      = 3'd0;
        hi_s      = 3'd0;
        asc_s     = 1'b1;
        swap_s    = 1'b0;
        case (stage_q)
            3'd0:    begin size_s = 4'd2; dist_s = 3'd1; end
            3'd1:    begin size_s = 4'd4; dist_s = 3'd2; end
            3'd2:    begin size_s = 4'd4; dist_s = 3'd1; end
            3'd3:    begin size_s = 4'd8; dist_s = 3'd4; end
            3'd4:    begin size_s = 4'd8; dist_s = 3'd2; end
            3'd5:    begin size_s = 4'd8; dist_s = 3'd1; end
            default: begin size_s = 4'd8; dist_s = 3'd1; end
        endcase
        // Each element finds its pair's lower index; direction depends only on that index.
        for (int j = 0; j < 8; j++) begin
            idx_s     = 3'(j);
            partner_s = idx_s ^ dist_s;
            lo_s      = idx_s & ~dist_s;
            hi_s      = idx_s | dist_s;
            asc_s     = (({1'b0, lo_s} & size_s) == 4'd0);
            swap_s    = cx_swap(r_q[lo_s], r_q[hi_s], asc_s);
            net_s[j]  = swap_s ? r_q[partner_s] : r_q[idx_s];
        end
    end

    // Next-state and next-output logic for the IDLE/LOAD/SORT/OUT sequence.
    always_comb begin
        state_d     = state_q;
        r_d         = r_q;
        cnt_d       = cnt_q;
        stage_d     = stage_q;
        k_d         = k_q;
        out_valid_d = 1'b0;
        out_data_d  = out_data_q;
        done_d      = 1'b0;
        case (state_q)
            IDLE: begin
                if (capture_s) begin
                    r_d[0]  = in_data;
                    cnt_d   = 3'd1;
                    state_d = LOAD;
                end else begin
                    cnt_d   = 3'd0;
                end
            end
            LOAD: begin
                if (capture_s) begin
                    r_d[cnt_q] = in_data;
                    cnt_d      = cnt_q + 3'd1;
                    if (cnt_q == 3'd7) begin
                        state_d = SORT;
                        stage_d = 3'd0;
                    end else begin
                        state_d = LOAD;
                    end
                end else begin
                    cnt_d = cnt_q;
                end
            end
            SORT: begin
                r_d = net_s;
                if (stage_q == 3'd5) begin
                    state_d = OUT;
                    stage_d = 3'd0;
                    k_d     = 3'd0;
                end else begin
                    stage_d = stage_q + 3'd1;
                end
            end
            OUT: begin
                // done_q marks the last element already presented: leave on the next edge.
                if (done_q) begin
                    state_d = IDLE;
                    k_d     = 3'd0;
                end else begin
                    out_valid_d = 1'b1;
                    out_data_d  = r_q[k_q];
                    done_d      = (k_q == 3'd7);
                    k_d         = k_q + 3'd1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State, sample array, counters and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            for (int i = 0; i < 8; i++) begin
                r_q[i] <= '0;
            end
            cnt_q       <= 3'd0;
            stage_q     <= 3'd0;
            k_q         <= 3'd0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            r_q         <= r_d;
            cnt_q       <= cnt_d;
            stage_q     <= stage_d;
            k_q         <= k_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            done_q      <= done_d;
        end
    end

endmodule

// File: tb/tb_bitonic_sort8_asc.sv
// Self-checking bench for bitonic_sort8_asc: directed and randomized bursts against a sorting model.
module tb_bitonic_sort8_asc;

    localparam int WIDTH = 8;

    typedef logic [WIDTH-1:0] burst_t [8];

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             in_valid = 1'b0;
    logic [WIDTH-1:0] in_data = '0;
    logic             in_ready;
    logic             out_valid;
    logic [WIDTH-1:0] out_data;
    logic             done;

    int               n_checks = 0;
    int               n_fail = 0;
    logic [WIDTH-1:0] last_out = '0;

    bitonic_sort8_asc #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .done      (done)
    );

    always #5 clk = ~clk;

    // Reference: plain selection sort of the burst, ascending.
    task automatic model_sort(input burst_t a, output burst_t s);
        logic [WIDTH-1:0] t;
        s = a;
        for (int i = 0; i < 8; i++) begin
            for (int j = i + 1; j < 8; j++) begin
                if (s[j] < s[i]) begin
                    t = s[i]; s[i] = s[j]; s[j] = t;
                end
            end
        end
    endtask

    task automatic send_burst(input burst_t d, input int gap_idx, input int gap_len);
        for (int i = 0; i < 8; i++) begin
            in_valid = 1'b1;
            in_data  = d[i];
            n_checks++;
            if (in_ready !== 1'b1) begin
                n_fail++;
                $display("FAIL load_ready sample %0d: in_ready=%b expected 1", i, in_ready);
            end
            @(posedge clk); #1;
            if (i == gap_idx) begin
                in_valid = 1'b0;
                in_data  = 8'h5A;
                repeat (gap_len) begin
                    @(posedge clk); #1;
                end
            end
        end
        in_valid = 1'b0;
    endtask

    // Follows the 15 cycles after the 8th capture; junk drives in_valid during SORT/OUT.
    task automatic expect_sorted(input burst_t d, input bit junk, input string tag);
        burst_t           e;
        logic             exp_v;
        logic             exp_done;
        logic [WIDTH-1:0] exp_d;
        model_sort(d, e);
        for (int c = 1; c <= 15; c++) begin
            if (junk && c <= 13) begin
                in_valid = 1'b1;
                in_data  = 8'h00;
            end else begin
                in_valid = 1'b0;
            end
            @(posedge clk); #1;
            exp_v    = (c >= 7) && (c <= 14);
            exp_done = (c == 14);
            if (c < 7) begin
                exp_d = last_out;
            end else if (c <= 14) begin
                exp_d = e[c - 7];
            end else begin
                exp_d = e[7];
            end
            n_checks++;
            if (out_valid !== exp_v) begin
                n_fail++;
                $display("FAIL %s out_valid cycle %0d: got %b expected %b", tag, c, out_valid, exp_v);
            end
            n_checks++;
            if (out_data !== exp_d) begin
                n_fail++;
                $display("FAIL %s out_data cycle %0d: got %h expected %h", tag, c, out_data, exp_d);
            end
            n_checks++;
            if (done !== exp_done) begin
                n_fail++;
                $display("FAIL %s done cycle %0d: got %b expected %b", tag, c, done, exp_done);
            end
            if (c <= 13) begin
                n_checks++;
                if (in_ready !== 1'b0) begin
                    n_fail++;
                    $display("FAIL %s busy_ready cycle %0d: got %b expected 0", tag, c, in_ready);
                end
            end
            if (c == 15) begin
                n_checks++;
                if (in_ready !== 1'b1) begin
                    n_fail++;
                    $display("FAIL %s idle_ready: got %b expected 1", tag, in_ready);
                end
            end
        end
        in_valid = 1'b0;
        last_out = e[7];
    endtask

    task automatic check_reset_outputs(input string tag);
        n_checks++;
        if (out_valid !== 1'b0 || out_data !== 8'h00 || done !== 1'b0 || in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL %s: got valid=%b data=%h done=%b ready=%b expected 0 00 0 1",
                     tag, out_valid, out_data, done, in_ready);
        end
    endtask

    task automatic quiet_window(input int cycles, input string tag);
        for (int c = 0; c < cycles; c++) begin
            @(posedge clk); #1;
            n_checks++;
            if (out_valid !== 1'b0) begin
                n_fail++;
                $display("FAIL %s cycle %0d: out_valid=%b expected 0", tag, c, out_valid);
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("reset_values");
        rst_n = 1'b1;
        @(posedge clk); #1;
        check_reset_outputs("after_release");
        last_out = '0;
    endtask

    task automatic test_directed();
        burst_t d;
        d = '{8'd8, 8'd7, 8'd6, 8'd5, 8'd4, 8'd3, 8'd2, 8'd1};
        send_burst(d, -1, 0);
        expect_sorted(d, 1'b0, "descending_in");
        d = '{8'h80, 8'h00, 8'hFF, 8'h7F, 8'h01, 8'hFE, 8'h40, 8'h10};
        send_burst(d, -1, 0);
        expect_sorted(d, 1'b0, "extremes");
        d = '{8'd5, 8'd5, 8'd3, 8'd3, 8'd9, 8'd9, 8'd0, 8'd0};
        send_burst(d, -1, 0);
        expect_sorted(d, 1'b0, "duplicates");
        d = '{8'hAA, 8'hAA, 8'hAA, 8'hAA, 8'hAA, 8'hAA, 8'hAA, 8'hAA};
        send_burst(d, -1, 0);
        expect_sorted(d, 1'b0, "all_equal");
    endtask

    task automatic test_gap_and_ignore();
        burst_t d;
        d = '{8'd8, 8'd7, 8'd6, 8'd5, 8'd4, 8'd3, 8'd2, 8'd1};
        send_burst(d, 3, 3);
        expect_sorted(d, 1'b0, "gapped");
        d = '{8'h80, 8'h00, 8'hFF, 8'h7F, 8'h01, 8'hFE, 8'h40, 8'h10};
        send_burst(d, -1, 0);
        expect_sorted(d, 1'b1, "ignored_input");
    endtask

    task automatic test_reset_load();
        burst_t d;
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1;
            in_data  = 8'(8'd50 + 8'(i));
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        check_reset_outputs("reset_in_load");
        @(posedge clk); #1;
        rst_n = 1'b1;
        last_out = '0;
        quiet_window(20, "no_out_after_load_reset");
        d = '{8'd3, 8'd1, 8'd2, 8'd0, 8'd7, 8'd6, 8'd5, 8'd4};
        send_burst(d, -1, 0);
        expect_sorted(d, 1'b0, "after_load_reset");
    endtask

    task automatic test_reset_out();
        burst_t d;
        d = '{8'd20, 8'd90, 8'd10, 8'd70, 8'd40, 8'd30, 8'd60, 8'd50};
        send_burst(d, -1, 0);
        repeat (10) @(posedge clk);
        #1;
        n_checks++;
        if (out_valid !== 1'b1 || out_data !== 8'd40) begin
            n_fail++;
            $display("FAIL out_k3: got valid=%b data=%h expected 1 28", out_valid, out_data);
        end
        rst_n = 1'b0;
        #1;
        check_reset_outputs("reset_in_out");
        @(posedge clk); #1;
        rst_n = 1'b1;
        last_out = '0;
        quiet_window(20, "no_out_after_out_reset");
    endtask

    task automatic test_back_to_back();
        burst_t a;
        burst_t b;
        a = '{8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7, 8'd8};
        b = '{8'd8, 8'd7, 8'd6, 8'd5, 8'd4, 8'd3, 8'd2, 8'd1};
        send_burst(a, -1, 0);
        expect_sorted(a, 1'b0, "b2b_first");
        send_burst(b, -1, 0);
        expect_sorted(b, 1'b0, "b2b_second");
    endtask

    task automatic test_random();
        burst_t d;
        for (int n = 0; n < 24; n++) begin
            for (int i = 0; i < 8; i++) begin
                if (n % 3 == 0) begin
                    d[i] = 8'($urandom_range(0, 3));
                end else begin
                    d[i] = 8'($urandom);
                end
            end
            send_burst(d, int'($urandom_range(0, 9)), int'($urandom_range(0, 3)));
            expect_sorted(d, 1'($urandom_range(0, 1)), "random");
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_gap_and_ignore();
        test_reset_load();
        test_reset_out();
        test_back_to_back();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
